// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch front end.
// The FSM state enum is also the debug view of pc_fetch_ctrl (state_q).
package pc_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      REDIR = 2'd3
   } pc_state_e;

   // Every instruction is one 32-bit word
   localparam int INSN_BYTES    = 4;
   localparam int PC_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry valid/ready capture register for redirect targets.
// Handshake: a word is taken on the rising edge where in_valid && in_ready;
// in_ready is high exactly while the entry is empty. clear empties the entry
// and wins over a capture in the same cycle.
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_data,
   input  logic            clear
);

   logic            valid_q;
   logic [XLEN-1:0] data_q;

   assign in_ready  = !valid_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // Capture a target when empty; hold it until cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q <= 1'b1;
         data_q  <= in_data;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter owner and fetch sequencer.
// Optional macro PC_MISALIGN_CHECK_EN: when defined, a misaligned redirect
// target is rejected with a misalign_err pulse instead of being truncated.
// Handshakes (both ports): a transfer happens on the rising edge where
// valid && ready are both high; the source holds data stable until then.
// fetch_valid is the only output that depends combinationally on an input
// (stall); everything else is registered or decoded from state_q.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            redirect_ready,
   input  logic            stall,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   input  logic            fetch_ready,
   output logic            flush,
   output logic            misalign_err
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            flush_q, flush_d;
   logic            mis_q, mis_d;

   logic            accept_en;
   logic            buf_in_ready;
   logic            buf_out_valid;
   logic [XLEN-1:0] buf_out_data;
   logic            buf_clear;
   logic            redirect_accept;

   // Redirects are only taken while the sequencer is running or frozen
   assign accept_en       = (state_q == FETCH) || (state_q == STALL);
   assign redirect_ready  = accept_en && buf_in_ready;
   assign redirect_accept = redirect_valid && redirect_ready;
   assign fetch_valid     = (state_q == FETCH) && !stall;
   assign fetch_pc        = pc_q;
   assign flush           = flush_q;
   assign misalign_err    = mis_q;

   pc_redirect_buf #(
      .XLEN (XLEN)
   ) u_redirect_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (redirect_valid && accept_en),
      .in_ready  (buf_in_ready),
      .in_data   (redirect_target),
      .out_valid (buf_out_valid),
      .out_data  (buf_out_data),
      .clear     (buf_clear)
   );

   // State, PC and the one-cycle pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   // Next-state, next-PC and pulse decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      flush_d   = 1'b0;
      mis_d     = 1'b0;
      buf_clear = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            // A redirect wins: the PC is not advanced even if a fetch
            // handshake completes in the same cycle.
            if (redirect_accept) begin
               state_d = REDIR;
            end else if (stall) begin
               state_d = STALL;
            end else if (fetch_valid && fetch_ready) begin
               pc_d = pc_q + XLEN'(INSN_BYTES);
            end
         end
         STALL: begin
            if (redirect_accept) begin
               state_d = REDIR;
            end else if (!stall) begin
               state_d = FETCH;
            end
         end
         REDIR: begin
            // Wait out the stall with the target parked in the buffer
            if (!stall) begin
               state_d   = FETCH;
               buf_clear = 1'b1;
               if (buf_out_valid) begin
`ifdef PC_MISALIGN_CHECK_EN
                  if (buf_out_data[PC_ALIGN_BITS-1:0] != '0) begin
                     mis_d = 1'b1;
                  end else begin
                     pc_d    = buf_out_data;
                     flush_d = 1'b1;
                  end
`else
                  pc_d    = buf_out_data & ~XLEN'(INSN_BYTES - 1);
                  flush_d = 1'b1;
`endif
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a behavioural model.
// Build with or without +define+PC_MISALIGN_CHECK_EN to match the RTL.
module tb_pc_fetch_ctrl;

   localparam logic [63:0] RV = 64'h8000_0000;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        redirect_ready;
   logic        stall;
   logic        fetch_valid;
   logic [63:0] fetch_pc;
   logic        fetch_ready;
   logic        flush;
   logic        misalign_err;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .XLEN         (64),
      .RESET_VECTOR (RV)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .redirect_ready  (redirect_ready),
      .stall           (stall),
      .fetch_valid     (fetch_valid),
      .fetch_pc        (fetch_pc),
      .fetch_ready     (fetch_ready),
      .flush           (flush),
      .misalign_err    (misalign_err)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_boot:    first cycle after reset, nothing offered
   // m_pend:    a redirect is parked, fetching is suspended
   // m_stalled: stall was seen last cycle, fetch resumes one cycle late
   logic        m_boot, m_pend, m_stalled, m_flush, m_mis;
   logic [63:0] m_pc, m_tgt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_boot    <= 1'b1;
         m_pend    <= 1'b0;
         m_stalled <= 1'b0;
         m_flush   <= 1'b0;
         m_mis     <= 1'b0;
         m_pc      <= RV;
         m_tgt     <= '0;
      end else begin
         m_flush <= 1'b0;
         m_mis   <= 1'b0;
         if (m_boot) begin
            m_boot <= 1'b0;
         end else if (m_pend) begin
            if (!stall) begin
               m_pend    <= 1'b0;
               m_stalled <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
               if (m_tgt % 4 != 0) begin
                  m_mis <= 1'b1;
               end else begin
                  m_pc    <= m_tgt;
                  m_flush <= 1'b1;
               end
`else
               m_pc    <= m_tgt - (m_tgt % 4);
               m_flush <= 1'b1;
`endif
            end
         end else if (redirect_valid) begin
            m_pend <= 1'b1;
            m_tgt  <= redirect_target;
         end else begin
            if (!m_stalled && !stall && fetch_ready) m_pc <= m_pc + 64'd4;
            m_stalled <= stall;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic exp_fv;
      logic exp_rr;
      exp_fv = !m_boot && !m_pend && !m_stalled && !stall;
      exp_rr = !m_boot && !m_pend;
      check("fetch_valid", fetch_valid, exp_fv);
      check("redirect_ready", redirect_ready, exp_rr);
      check("fetch_pc", fetch_pc, m_pc);
      check("flush", flush, m_flush);
      check("misalign_err", misalign_err, m_mis);
      if (rst_n && exp_fv && fetch_ready) exp_q.push_back(m_pc);
      if (rst_n && fetch_valid && fetch_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_fetch", fetch_pc, 64'hXXXX_XXXX_XXXX_XXXX);
         end else begin
            check("fetch_addr", fetch_pc, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_random();
      logic [63:0] t;
      redirect_valid = ($urandom_range(0, 3) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
         0:       t = {$urandom(), $urandom()} & ~64'h3;
         1:       t = {$urandom(), $urandom()};
         2:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         default: t = 64'($urandom_range(0, 255));
      endcase
      redirect_target = t;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] old_pc;
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      stall           = 1'b0;
      fetch_ready     = 1'b1;

      // reset values
      sample();
      check("rst_pc", fetch_pc, RV);
      check("rst_fv", fetch_valid, 0);
      check("rst_rr", redirect_ready, 0);
      check("rst_flush", flush, 0);
      tick();
      rst_n = 1'b1;
      sample();
      check("boot_fv", fetch_valid, 0);

      // sequential fetch from the reset vector
      tick(); sample();
      check("seq0_pc", fetch_pc, 64'h8000_0000);
      check("seq0_fv", fetch_valid, 1);
      tick(); sample();
      check("seq1_pc", fetch_pc, 64'h8000_0004);
      tick(); sample();
      check("seq2_pc", fetch_pc, 64'h8000_0008);
      check("seq2_flush", flush, 0);

      // move to 0x10, then hold fetch_ready low for three cycles
      tick();
      redirect_valid = 1'b1; redirect_target = 64'h10;
      sample(); check("r10_rr", redirect_ready, 1);
      tick();
      redirect_valid = 1'b0;
      sample(); check("r10_n1_fv", fetch_valid, 0);
      tick();
      fetch_ready = 1'b0;
      sample(); check("hold0_pc", fetch_pc, 64'h10); check("hold0_flush", flush, 1);
      tick(); sample(); check("hold1_pc", fetch_pc, 64'h10); check("hold1_flush", flush, 0);
      tick(); sample(); check("hold2_pc", fetch_pc, 64'h10); check("hold2_fv", fetch_valid, 1);
      tick();
      fetch_ready = 1'b1;
      sample(); check("hold3_pc", fetch_pc, 64'h10);
      tick(); sample(); check("adv_pc", fetch_pc, 64'h14);

      // redirect latency to 0x200
      tick();
      redirect_valid = 1'b1; redirect_target = 64'h200;
      sample(); check("r200_rr", redirect_ready, 1);
      tick();
      redirect_valid = 1'b0;
      sample(); check("r200_n1_fv", fetch_valid, 0);
      tick(); sample();
      check("r200_n2_pc", fetch_pc, 64'h200);
      check("r200_n2_flush", flush, 1);
      check("r200_n2_fv", fetch_valid, 1);
      tick(); sample();
      check("r200_n3_flush", flush, 0);
      check("r200_n3_pc", fetch_pc, 64'h204);

      // redirect to 0x300 under a 4-cycle stall, second redirect offered
      tick();
      redirect_valid = 1'b1; redirect_target = 64'h300; stall = 1'b1;
      sample(); check("r300_rr", redirect_ready, 1);
      tick();
      redirect_target = 64'h400;
      sample(); check("r300_w1_rr", redirect_ready, 0);
      tick(); sample(); check("r300_w2_rr", redirect_ready, 0);
      tick(); sample(); check("r300_w3_rr", redirect_ready, 0);
      tick();
      stall = 1'b0;
      sample(); check("r300_w4_rr", redirect_ready, 0);
      tick();
      redirect_valid = 1'b0;
      sample(); check("r300_pc", fetch_pc, 64'h300); check("r300_flush", flush, 1);
      tick(); sample(); check("r300_next_pc", fetch_pc, 64'h304);

      // wrap at the top of the address space
      tick();
      redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      sample();
      tick();
      redirect_valid = 1'b0;
      tick(); sample(); check("wrap_top_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(); sample(); check("wrap_pc", fetch_pc, 64'h0); check("wrap_mis", misalign_err, 0);

      // misaligned redirect to 0x202
      tick();
      old_pc = 64'h4;
      redirect_valid = 1'b1; redirect_target = 64'h202;
      sample(); check("mis_pre_pc", fetch_pc, old_pc);
      tick();
      redirect_valid = 1'b0;
      sample(); check("mis_n1_fv", fetch_valid, 0);
      tick(); sample();
`ifdef PC_MISALIGN_CHECK_EN
      check("mis_err", misalign_err, 1);
      check("mis_flush", flush, 0);
      check("mis_pc", fetch_pc, old_pc);
`else
      check("mis_err", misalign_err, 0);
      check("mis_flush", flush, 1);
      check("mis_pc", fetch_pc, 64'h200);
`endif
      tick(); sample(); check("mis_err_end", misalign_err, 0);

      // randomized run with occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (rst_n && $urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         drive_random();
      end

      tick();
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      stall          = 1'b0;
      sample();
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter owner and fetch sequencer for the core front end. It issues sequential instruction fetch addresses to instruction memory through a valid/ready handshake. It accepts resolved branch/jump targets from the branch-target adder through a second valid/ready handshake. A one-entry redirect buffer lets redirects wait out pipeline stalls, and the block pulses `flush` when the new path starts.

## Interface
Parameters:
- `XLEN`, 64: PC width.
- `RESET_VECTOR`, 64'h0000_0000_0000_0000: first fetch address after reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `redirect_valid` input 1: branch target presented.
- `redirect_target` input XLEN: computed target (pc + offset).
- `redirect_ready` output 1: redirect buffer empty; target will be captured this cycle.
- `stall` input 1: hazard freeze from the pipeline.
- `fetch_valid` output 1: `fetch_pc` is a request.
- `fetch_pc` output XLEN: fetch address.
- `fetch_ready` input 1: instruction memory accepts the request.
- `flush` output 1: one-cycle pulse; younger in-flight instructions are killed.
- `misalign_err` output 1: one-cycle pulse; rejected misaligned target (see Configuration).

## Operation
- FSM states: BOOT, FETCH, STALL, REDIR. The state is held in a register.
- BOOT (reset state):
  - `fetch_valid`=0, `redirect_ready`=0.
  - Moves unconditionally to FETCH on the first clock edge after reset release.
- FETCH:
  - `fetch_valid` = !`stall`; `redirect_ready`=1.
  - Priority order:
    1. Redirect accepted → REDIR. The PC is not incremented. A fetch handshake in the same cycle still counts as completed.
    2. Else `stall` → STALL.
    3. Else `fetch_valid`&&`fetch_ready` → pc <= pc+4.
    4. Else hold.
- STALL:
  - `fetch_valid`=0, `redirect_ready`=1, pc held.
  - Redirect accepted → REDIR; else !`stall` → FETCH.
- REDIR:
  - `fetch_valid`=0, `redirect_ready`=0. Further redirects are back-pressured.
  - If `stall`, stay in REDIR with the buffer held.
  - Else pc <= buffered target, `flush`<=1, buffer cleared, → FETCH.
- Arithmetic: pc+4 is modulo 2^XLEN. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no error.
- A redirect accept requires `redirect_valid`&&`redirect_ready`. The target is captured exactly as presented.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - Any buffered redirect is discarded.

## Timing
- Reset values:
  - `fetch_pc`=RESET_VECTOR.
  - `fetch_valid`=0, `redirect_ready`=0, `flush`=0, `misalign_err`=0.
  - State=BOOT, buffer empty.
- First request: `fetch_valid`=1 in the first cycle after the first edge following reset release.
- Redirect latency, with no stall:
  - Accept in cycle N.
  - Cycle N+1: REDIR, `fetch_valid`=0.
  - Cycle N+2: `fetch_pc`=target, `fetch_valid`=1, `flush`=1 for this one cycle only.
- Sequential throughput: one fetch per cycle while `fetch_ready`=1 and `stall`=0.
- `fetch_valid` depends combinationally on `stall`. All other outputs are registered or decoded from state only.
- `fetch_pc` stays stable while `fetch_valid`=1 and `fetch_ready`=0.

## Configuration
- Macro: `PC_MISALIGN_CHECK_EN`.
- Defined:
  - In REDIR, a target with bits [1:0]≠0 is not loaded. The PC is unchanged.
  - `misalign_err` pulses for one cycle, `flush` stays 0, the buffer is cleared, → FETCH.
- Undefined:
  - Target bits [1:0] are cleared before the load.
  - `misalign_err` is tied to 0.

## Structure
- Shared package `pc_pkg` holds:
  - the FSM state enum (BOOT, FETCH, STALL, REDIR);
  - `INSN_BYTES`=4;
  - `PC_ALIGN_BITS`=2.
- One sub-module, `pc_redirect_buf`: the one-entry valid/ready capture register.
  - Ports: clk, rst_n, in valid/ready/data, out valid/data, clear.

## Test plan
- Reset release with RESET_VECTOR=64'h8000_0000 and `fetch_ready`=1:
  - `fetch_pc` runs 8000_0000, 8000_0004, 8000_0008 on consecutive cycles.
  - `flush`=0 throughout.
- `fetch_ready`=0 for 3 cycles at pc 64'h10:
  - `fetch_pc` holds 64'h10 with `fetch_valid`=1.
  - It advances to 64'h14 one cycle after `fetch_ready` returns to 1.
- Redirect to 64'h200 in cycle N:
  - Cycle N+1: `fetch_valid`=0.
  - Cycle N+2: `fetch_pc`=64'h200 with `flush`=1 for exactly one cycle.
- Redirect to 64'h300 accepted while `stall`=1 for 4 cycles, then a second redirect offered:
  - `redirect_ready`=0 during the wait; the second redirect is not taken.
  - `fetch_pc`=64'h300 one cycle after `stall` falls.
- pc=64'hFFFF_FFFF_FFFF_FFFC with a fetch accepted:
  - Next `fetch_pc`=0; no error.
- Redirect to 64'h202:
  - With the macro: `misalign_err` pulses, `flush`=0, the PC stays on the old path.
  - Without the macro: `fetch_pc`=64'h200 with `flush`=1.
